// File: rtl/irq_pkg.sv
// Shared types and helpers for the prioritising interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  // Byte distance between consecutive handler entry points.
  localparam int VEC_STRIDE = 4;

  // Upper bound on source count; helpers work on vectors of this width.
  localparam int MAX_SRC = 32;

  // Index of the highest set bit (0 when the vector is empty).
  function automatic int msb_index(input logic [MAX_SRC-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [MAX_SRC-1:0] onehot(input int idx);
    return MAX_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchroniser for one asynchronous request pin, followed by a
// rising-edge detector. The rise pulse lasts one cycle, so a level held high
// produces exactly one event.
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchroniser chain plus the delayed copy used for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Prioritising interrupt controller in front of the pipeline's trap entry.
// Synchronises and edge-detects N_SRC request pins, keeps a pending bit per
// source, picks the highest eligible index, and runs a req/ack handshake.
// Acknowledged sources are tracked in isr until the handler's mret.
// Build option: define IRQ_NEST_EN to allow a higher-index source to preempt
// an in-service handler; without it only one source is in service at a time.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned          N_SRC    = 3,
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     VEC_BASE = WIDTH'(32'h0000_0100),
  localparam int unsigned         CW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             ie,
  input  logic             int_ack,
  input  logic             mret,
  output logic             int_req,
  output logic [CW-1:0]    int_cause,
  output logic [WIDTH-1:0] int_vec,
  output logic [N_SRC-1:0] pending_o,
  output logic             in_service
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] isr_q;
  logic [N_SRC-1:0] isr_d;
  irq_state_e       state_q;
  irq_state_e       state_d;
  logic [CW-1:0]    cause_q;
  logic [CW-1:0]    cause_d;
  logic [CW-1:0]    sel;
  logic             eligible;
  logic             ack_take;
  logic             mret_take;

  // One synchroniser/edge detector per source.
  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .pin  (irq_in[g]),
      .rise (rise[g])
    );
  end

  // Handshake events that actually take effect: ack only while requesting,
  // mret only when something is in service (which implies not IDLE).
  assign ack_take  = (state_q == REQ) && int_ack;
  assign mret_take = mret && (state_q != IDLE) && (|isr_q);

`ifdef IRQ_NEST_EN
  int isr_top;
  assign isr_top = msb_index(MAX_SRC'(isr_q));
`endif

  // Fixed-priority arbiter: highest pending index that may run now.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    eligible = 1'b0;
    sel      = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
`ifdef IRQ_NEST_EN
      if (pending_q[i] && ((isr_q == '0) || (i > isr_top))) begin
`else
      if (pending_q[i] && (isr_q == '0)) begin
`endif
        eligible = 1'b1;
        sel      = CW'(i);
      end
    end
    eligible = eligible & ie;
  end

  // Pending bits: the acknowledged source is cleared, then fresh edges are
  // merged in, so an edge in the ack cycle survives as a new event.
  always_comb begin
    pending_d = pending_q;
    if (ack_take) pending_d = pending_d & ~N_SRC'(onehot(int'(cause_q)));
    pending_d = pending_d | rise;
  end

  // In-service set: mret retires the highest level, ack adds the granted one.
  always_comb begin
    isr_d = isr_q;
    if (mret_take) isr_d = isr_d & ~N_SRC'(onehot(msb_index(MAX_SRC'(isr_q))));
    if (ack_take)  isr_d = isr_d | N_SRC'(onehot(int'(cause_q)));
  end

  // Handshake FSM next state; the granted cause is frozen while in REQ.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (eligible) begin
          state_d = REQ;
          cause_d = sel;
        end
      end
      REQ: begin
        if (ack_take) state_d = SVC;
      end
      SVC: begin
        if (mret_take && (isr_d == '0)) begin
          state_d = IDLE;
`ifdef IRQ_NEST_EN
        end else if (eligible) begin
          state_d = REQ;
          cause_d = sel;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, cause, pending and in-service registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cause_q   <= '0;
      pending_q <= '0;
      isr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
    end
  end

  assign int_req    = (state_q == REQ);
  assign int_cause  = cause_q;
  assign int_vec    = VEC_BASE + (WIDTH'(cause_q) * WIDTH'(VEC_STRIDE));
  assign pending_o  = pending_q;
  assign in_service = |isr_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios with constant
// expectations, then randomized traffic against a transaction-level model.
module tb_irq_controller;

`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_in;
  logic        ie;
  logic        int_ack;
  logic        mret;
  logic        int_req;
  logic [1:0]  int_cause;
  logic [31:0] int_vec;
  logic [2:0]  pending_o;
  logic        in_service;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: pin history, pending set, list of in-service sources,
  // and the outstanding request (if any).
  bit [2:0] h1, h2, h3;
  bit [2:0] m_pend;
  bit       m_req;
  int       m_cause;
  int       m_isr[$];

  irq_controller dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .ie         (ie),
    .int_ack    (int_ack),
    .mret       (mret),
    .int_req    (int_req),
    .int_cause  (int_cause),
    .int_vec    (int_vec),
    .pending_o  (pending_o),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_step();
    bit [2:0] ev;
    int top, sel, old;
    bit elig, take_ack, take_mret;
    if (!rst) begin
      m_pend = '0; m_req = 1'b0; m_cause = 0; m_isr.delete();
      h1 = '0; h2 = '0; h3 = '0;
      return;
    end
    // An event lands in pending two samples after the pin is first seen high.
    ev = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = irq_in;
    top = -1;
    foreach (m_isr[k]) if (m_isr[k] > top) top = m_isr[k];
    take_ack  = m_req && (int_ack === 1'b1);
    take_mret = (mret === 1'b1) && (m_isr.size() > 0);
    elig = 1'b0; sel = 0;
    for (int i = 0; i < 3; i++)
      if (m_pend[i] && ie && (NEST ? (i > top) : (m_isr.size() == 0))) begin
        elig = 1'b1; sel = i;
      end
    old = m_cause;
    if (m_req) begin
      if (take_ack) m_req = 1'b0;
    end else if (m_isr.size() == 0) begin
      if (elig) begin m_req = 1'b1; m_cause = sel; end
    end else begin
      if (!(take_mret && m_isr.size() == 1) && NEST && elig) begin
        m_req = 1'b1; m_cause = sel;
      end
    end
    if (take_ack) m_pend[old] = 1'b0;
    m_pend |= ev;
    if (take_mret)
      for (int k = 0; k < m_isr.size(); k++)
        if (m_isr[k] == top) begin m_isr.delete(k); break; end
    if (take_ack) m_isr.push_back(old);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] p);
    irq_in = p; tick(); irq_in = '0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1; tick(); mret = 1'b0;
  endtask

  task automatic wait_req(input int budget, output int cycles);
    cycles = 0;
    while (int_req !== 1'b1 && cycles < budget) begin tick(); cycles++; end
  endtask

  task automatic test_reset();
    rst = 1'b0; ie = 1'b0; int_ack = 1'b0; mret = 1'b0; irq_in = '0;
    tick(); tick();
    n_vec++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", int_req); end
    n_vec++; if (int_cause !== 2'd0) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", int_cause); end
    n_vec++; if (int_vec !== 32'h100) begin n_bad++; $display("FAIL reset_vec: got %h want 00000100", int_vec); end
    n_vec++; if (pending_o !== 3'b000) begin n_bad++; $display("FAIL reset_pend: got %b want 000", pending_o); end
    n_vec++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL reset_isv: got %b want 0", in_service); end
    rst = 1'b1;
    pulse(3'b011); tick(); tick(); tick();
    n_vec++; if (pending_o !== 3'b011) begin n_bad++; $display("FAIL gated_pend: got %b want 011", pending_o); end
    ie = 1'b1; tick();
    n_vec++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL midreq_req: got %b want 1", int_req); end
    rst = 1'b0; tick();
    n_vec++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL midrst_req: got %b want 0", int_req); end
    n_vec++; if (pending_o !== 3'b000) begin n_bad++; $display("FAIL midrst_pend: got %b want 000", pending_o); end
    n_vec++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL midrst_isv: got %b want 0", in_service); end
    n_vec++; if (int_vec !== 32'h100) begin n_bad++; $display("FAIL midrst_vec: got %h want 00000100", int_vec); end
    rst = 1'b1; tick(); tick(); tick(); tick();
    n_vec++; if (pending_o !== 3'b000 || int_req !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: pend %b req %b want 000/0", pending_o, int_req); end
  endtask

  task automatic test_basic();
    int c;
    ie = 1'b1;
    pulse(3'b010); wait_req(10, c);
    n_vec++; if (c !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", c); end
    n_vec++; if (int_cause !== 2'd1) begin n_bad++; $display("FAIL basic_cause: got %0d want 1", int_cause); end
    n_vec++; if (int_vec !== 32'h104) begin n_bad++; $display("FAIL basic_vec: got %h want 00000104", int_vec); end
    do_ack();
    n_vec++; if (int_req !== 1'b0 || in_service !== 1'b1) begin n_bad++; $display("FAIL basic_ack: req %b isv %b want 0/1", int_req, in_service); end
    n_vec++; if (pending_o !== 3'b000) begin n_bad++; $display("FAIL basic_pend: got %b want 000", pending_o); end
    do_mret(); tick(); tick();
    n_vec++; if (in_service !== 1'b0 || int_req !== 1'b0) begin n_bad++; $display("FAIL basic_mret: isv %b req %b want 0/0", in_service, int_req); end
  endtask

  task automatic test_priority();
    int c;
    pulse(3'b101); wait_req(10, c);
    n_vec++; if (int_cause !== 2'd2) begin n_bad++; $display("FAIL prio_first: got %0d want 2", int_cause); end
    n_vec++; if (int_vec !== 32'h108) begin n_bad++; $display("FAIL prio_vec2: got %h want 00000108", int_vec); end
    do_ack(); tick(); tick();
    n_vec++; if (int_req !== 1'b0 || pending_o !== 3'b001) begin n_bad++; $display("FAIL prio_blocked: req %b pend %b want 0/001", int_req, pending_o); end
    do_mret(); wait_req(4, c);
    n_vec++; if (c !== 1 || int_cause !== 2'd0) begin n_bad++; $display("FAIL prio_second: wait %0d cause %0d want 1/0", c, int_cause); end
    n_vec++; if (int_vec !== 32'h100) begin n_bad++; $display("FAIL prio_vec0: got %h want 00000100", int_vec); end
    do_ack(); do_mret();
    n_vec++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL prio_done: got %b want 0", in_service); end
  endtask

  task automatic test_freeze();
    int c;
    pulse(3'b001); wait_req(10, c);
    pulse(3'b100); tick(); tick(); tick();
    n_vec++; if (int_cause !== 2'd0 || int_req !== 1'b1) begin n_bad++; $display("FAIL freeze_cause: cause %0d req %b want 0/1", int_cause, int_req); end
    n_vec++; if (pending_o !== 3'b101) begin n_bad++; $display("FAIL freeze_pend: got %b want 101", pending_o); end
    ie = 1'b0; tick();
    n_vec++; if (int_req !== 1'b1 || int_vec !== 32'h100) begin n_bad++; $display("FAIL freeze_ie: req %b vec %h want 1/00000100", int_req, int_vec); end
    ie = 1'b1;
    do_ack();
`ifdef IRQ_NEST_EN
    wait_req(4, c);
    n_vec++; if (c !== 1 || int_cause !== 2'd2) begin n_bad++; $display("FAIL nest_preempt: wait %0d cause %0d want 1/2", c, int_cause); end
    do_ack(); do_mret();
    n_vec++; if (in_service !== 1'b1) begin n_bad++; $display("FAIL nest_unwind1: got %b want 1", in_service); end
    do_mret();
`else
    tick(); tick(); tick();
    n_vec++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL flat_nopreempt: got %b want 0", int_req); end
    do_mret(); wait_req(4, c);
    n_vec++; if (c !== 1 || int_cause !== 2'd2) begin n_bad++; $display("FAIL flat_after_mret: wait %0d cause %0d want 1/2", c, int_cause); end
    do_ack(); do_mret();
`endif
    n_vec++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL freeze_done: got %b want 0", in_service); end
  endtask

  task automatic test_ie_gate();
    ie = 1'b0;
    pulse(3'b001); tick(); tick(); tick();
    n_vec++; if (pending_o !== 3'b001 || int_req !== 1'b0) begin n_bad++; $display("FAIL ie_gate: pend %b req %b want 001/0", pending_o, int_req); end
    ie = 1'b1; tick();
    n_vec++; if (int_req !== 1'b1 || int_cause !== 2'd0) begin n_bad++; $display("FAIL ie_release: req %b cause %0d want 1/0", int_req, int_cause); end
    do_ack(); do_mret();
  endtask

  task automatic test_corners();
    int c;
    int_ack = 1'b1; mret = 1'b1; tick(); int_ack = 1'b0; mret = 1'b0;
    n_vec++; if (int_req !== 1'b0 || in_service !== 1'b0 || pending_o !== 3'b000) begin n_bad++; $display("FAIL stray_idle: req %b isv %b pend %b want 0/0/000", int_req, in_service, pending_o); end
    // Second edge on the granted source lands exactly in the ack cycle.
    pulse(3'b010); wait_req(10, c);
    irq_in = 3'b010; tick(); irq_in = '0; tick();
    do_ack();
    n_vec++; if (pending_o !== 3'b010 || in_service !== 1'b1) begin n_bad++; $display("FAIL ack_edge: pend %b isv %b want 010/1", pending_o, in_service); end
    do_mret(); wait_req(4, c);
    n_vec++; if (int_cause !== 2'd1 || int_req !== 1'b1) begin n_bad++; $display("FAIL ack_edge_rerun: cause %0d req %b want 1/1", int_cause, int_req); end
    do_ack(); do_mret();
    // A held level is a single event.
    ie = 1'b0; irq_in = 3'b001;
    for (int i = 0; i < 5; i++) tick();
    ie = 1'b1; wait_req(3, c);
    do_ack(); do_mret();
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (int_req !== 1'b0 || pending_o !== 3'b000) begin n_bad++; $display("FAIL level_once: req %b pend %b want 0/000", int_req, pending_o); end
    irq_in = '0; tick(); tick(); tick();
`ifdef IRQ_NEST_EN
    pulse(3'b001); wait_req(10, c); do_ack();
    pulse(3'b100); wait_req(6, c);
    n_vec++; if (int_cause !== 2'd2) begin n_bad++; $display("FAIL ackmret_cause: got %0d want 2", int_cause); end
    int_ack = 1'b1; mret = 1'b1; tick(); int_ack = 1'b0; mret = 1'b0;
    n_vec++; if (in_service !== 1'b1 || int_req !== 1'b0) begin n_bad++; $display("FAIL ackmret_isv: isv %b req %b want 1/0", in_service, int_req); end
    do_mret();
    n_vec++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL ackmret_single: got %b want 0", in_service); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_vec;
    rst = 1'b0; irq_in = '0; int_ack = 1'b0; mret = 1'b0; ie = 1'b1;
    tick(); tick();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
      ie = ($urandom_range(0, 9) != 0);
      int_ack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 29) == 0);
      mret = (m_isr.size() > 0 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 29) == 0);
      tick();
      exp_vec = 32'h100 + 32'(4 * m_cause);
      n_vec++; if (int_req !== m_req) begin n_bad++; $display("FAIL rnd_req @%0d: got %b want %b", n, int_req, m_req); end
      n_vec++; if (int_cause !== 2'(m_cause)) begin n_bad++; $display("FAIL rnd_cause @%0d: got %0d want %0d", n, int_cause, m_cause); end
      n_vec++; if (int_vec !== exp_vec) begin n_bad++; $display("FAIL rnd_vec @%0d: got %h want %h", n, int_vec, exp_vec); end
      n_vec++; if (pending_o !== m_pend) begin n_bad++; $display("FAIL rnd_pend @%0d: got %b want %b", n, pending_o, m_pend); end
      n_vec++; if (in_service !== (m_isr.size() > 0)) begin n_bad++; $display("FAIL rnd_isv @%0d: got %b want %b", n, in_service, m_isr.size() > 0); end
    end
    rst = 1'b1; int_ack = 1'b0; mret = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_freeze();
    test_ie_gate();
    test_corners();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
